// File: rtl/global_pkg.sv
// Shared ucontroller definitions: ALU command encoding and ASCII conversion constants.
package global_pkg;

  // Encodings 21..31 are undefined and decode as op_nop inside the ALU.
  typedef enum logic [4:0] {
    op_nop        = 5'd0,
    op_lda        = 5'd1,
    op_ldb        = 5'd2,
    op_ldacc      = 5'd3,
    op_ldid       = 5'd4,
    op_mvacc2id   = 5'd5,
    op_mvacc2a    = 5'd6,
    op_mvacc2b    = 5'd7,
    op_add        = 5'd8,
    op_sub        = 5'd9,
    op_shiftl     = 5'd10,
    op_shiftr     = 5'd11,
    op_and        = 5'd12,
    op_or         = 5'd13,
    op_xor        = 5'd14,
    op_cmpe       = 5'd15,
    op_cmpl       = 5'd16,
    op_cmpg       = 5'd17,
    op_ascii2bin  = 5'd18,
    op_bin2ascii  = 5'd19,
    op_oeacc      = 5'd20
  } alu_op;

  localparam logic [7:0] ASCII_0       = 8'h30;
  localparam logic [7:0] ASCII_9       = 8'h39;
  localparam logic [7:0] ASCII_UA      = 8'h41;
  localparam logic [7:0] ASCII_UF      = 8'h46;
  localparam logic [7:0] ASCII_LA      = 8'h61;
  localparam logic [7:0] ASCII_LF      = 8'h66;
  localparam logic [7:0] ASCII_INVALID = 8'hFF;

endpackage

// File: rtl/alu_core_if.sv
// CPU-side command/data bus of the ALU: decoder command, operand in, ACC out with drive enable.
// Handshake: there is no valid/ready; one command is presented every cycle, op_nop means idle.
interface alu_core_if;
  logic [4:0] op;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rdata_oe;

  modport master (output op, output wdata, input rdata, input rdata_oe);
  modport slave  (input op, input wdata, output rdata, output rdata_oe);
endinterface

// File: rtl/alu_ascii_conv.sv
// Combinational ASCII hex-digit <-> 4-bit value converter, both directions from one source byte.
module alu_ascii_conv
  import global_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] a2b_o,
  output logic       a2b_valid_o,
  output logic [7:0] b2a_o
);

  logic [3:0] nib;

  always_comb begin
    a2b_o       = ASCII_INVALID;
    a2b_valid_o = 1'b0;
    if (a_i >= ASCII_0 && a_i <= ASCII_9) begin
      a2b_o       = a_i - ASCII_0;
      a2b_valid_o = 1'b1;
    end else if (a_i >= ASCII_UA && a_i <= ASCII_UF) begin
      a2b_o       = a_i - ASCII_UA + 8'd10;
      a2b_valid_o = 1'b1;
    end else if (a_i >= ASCII_LA && a_i <= ASCII_LF) begin
      a2b_o       = a_i - ASCII_LA + 8'd10;
      a2b_valid_o = 1'b1;
    end
  end

  // Upper nibble of the source is ignored; letters are always emitted uppercase.
  assign nib   = a_i[3:0];
  assign b2a_o = (nib < 4'd10) ? (ASCII_0 + {4'b0000, nib})
                               : (ASCII_UA + {4'b0000, nib} - 8'd10);

endmodule

// File: rtl/alu_core.sv
// ucontroller datapath: A/B/ACC/INDEX registers, Z/N/C/E flags, one command committed per clock.
module alu_core
  import global_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] alu_op_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       data_oe_o,
  output logic [7:0] index_o,
  output logic [7:0] acc_o,
  output logic       flag_z_o,
  output logic       flag_n_o,
  output logic       flag_c_o,
  output logic       flag_e_o
);

  generate
    if (DATA_WIDTH != 8) begin : g_bad_width
      $error("alu_core supports DATA_WIDTH=8 only");
    end
  endgenerate

  alu_op      op;
  logic [7:0] a_q, a_d, b_q, b_d, acc_q, acc_d, index_q, index_d;
  logic       z_q, z_d, n_q, n_d, c_q, c_d, e_q, e_d;
  logic [7:0] res;
  logic       upd_zn;
  logic [7:0] a2b, b2a;
  logic       a2b_valid;

  alu_ascii_conv u_ascii (
    .a_i         (a_q),
    .a2b_o       (a2b),
    .a2b_valid_o (a2b_valid),
    .b2a_o       (b2a)
  );

  assign op = alu_op'(alu_op_i);

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    index_d = index_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    e_d     = e_q;
    res     = acc_q;
    upd_zn  = 1'b0;
    case (op)
      op_lda:       a_d     = data_i;
      op_ldb:       b_d     = data_i;
      op_ldacc:     acc_d   = data_i;
      op_ldid:      index_d = data_i;
      op_mvacc2id:  index_d = acc_q;
      op_mvacc2a:   a_d     = acc_q;
      op_mvacc2b:   b_d     = acc_q;
      op_add:       begin {c_d, res} = {1'b0, a_q} + {1'b0, b_q}; upd_zn = 1'b1; end
      // Bit 8 of the 9-bit difference is the unsigned borrow.
      op_sub:       begin {c_d, res} = {1'b0, a_q} - {1'b0, b_q}; upd_zn = 1'b1; end
      op_shiftl:    begin c_d = acc_q[7]; res = {acc_q[6:0], 1'b0}; upd_zn = 1'b1; end
      op_shiftr:    begin c_d = acc_q[0]; res = {1'b0, acc_q[7:1]}; upd_zn = 1'b1; end
      op_and:       begin c_d = 1'b0; res = a_q & b_q; upd_zn = 1'b1; end
      op_or:        begin c_d = 1'b0; res = a_q | b_q; upd_zn = 1'b1; end
      op_xor:       begin c_d = 1'b0; res = a_q ^ b_q; upd_zn = 1'b1; end
      op_cmpe:      e_d = (a_q == b_q);
      op_cmpl:      e_d = (a_q < b_q);
      op_cmpg:      e_d = (a_q > b_q);
      op_ascii2bin: begin res = a2b; e_d = a2b_valid; upd_zn = 1'b1; end
      op_bin2ascii: begin res = b2a; e_d = 1'b1; upd_zn = 1'b1; end
      default:      ;
    endcase
    if (upd_zn) begin
      acc_d = res;
      z_d   = (res == 8'h00);
      n_d   = res[7];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      acc_q   <= 8'h00;
      index_q <= 8'h00;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      e_q     <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      index_q <= index_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      e_q     <= e_d;
    end
  end

  // Bus drive is combinational so the decoder can read ACC in the same cycle it asks.
  assign data_oe_o = rst_n && (op == op_oeacc);
  assign data_o    = data_oe_o ? acc_q : 8'h00;
  assign index_o   = index_q;
  assign acc_o     = acc_q;
  assign flag_z_o  = z_q;
  assign flag_n_o  = n_q;
  assign flag_c_o  = c_q;
  assign flag_e_o  = e_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core with a cycle-tagged expected queue and a separate monitor.
module tb_alu_core;
  import global_pkg::*;

  typedef struct packed {
    logic [7:0] acc;
    logic [7:0] idx;
    logic       z;
    logic       n;
    logic       c;
    logic       e;
  } st_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] index_o, acc_o;
  logic       flag_z_o, flag_n_o, flag_c_o, flag_e_o;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  st_t        cur;

  // Scoreboard: kind 0 = registered state, kind 1 = bus (acc field = data_o, e field = data_oe_o).
  st_t        exp_q[$];
  int         tgt_q[$];
  bit         kind_q[$];
  string      name_q[$];

  alu_core_if bus ();

  alu_core #(.DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_op_i  (bus.op),
    .data_i    (bus.wdata),
    .data_o    (bus.rdata),
    .data_oe_o (bus.rdata_oe),
    .index_o   (index_o),
    .acc_o     (acc_o),
    .flag_z_o  (flag_z_o),
    .flag_n_o  (flag_n_o),
    .flag_c_o  (flag_c_o),
    .flag_e_o  (flag_e_o)
  );

  // Clock / reset / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic st_t act_state();
    return '{acc: acc_o, idx: index_o, z: flag_z_o, n: flag_n_o, c: flag_c_o, e: flag_e_o};
  endfunction

  function automatic st_t act_bus();
    st_t b;
    b     = '0;
    b.acc = bus.rdata;
    b.e   = bus.rdata_oe;
    return b;
  endfunction

  function automatic st_t mk_bus(input logic oe, input logic [7:0] dout);
    st_t b;
    b     = '0;
    b.acc = dout;
    b.e   = oe;
    return b;
  endfunction

  task automatic compare(input string nm, input bit kind, input st_t act, input st_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (kind)
        $display("FAIL %s: got data_o=%02h oe=%b, want data_o=%02h oe=%b",
                 nm, act.acc, act.e, exp.acc, exp.e);
      else
        $display("FAIL %s: got acc=%02h idx=%02h znce=%b%b%b%b, want acc=%02h idx=%02h znce=%b%b%b%b",
                 nm, act.acc, act.idx, act.z, act.n, act.c, act.e,
                 exp.acc, exp.idx, exp.z, exp.n, exp.c, exp.e);
    end
  endtask

  // Driver tasks
  task automatic push(input int tgt, input bit kind, input st_t e, input string nm);
    tgt_q.push_back(tgt);
    kind_q.push_back(kind);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic issue(input logic [4:0] op, input logic [7:0] d, input st_t nxt, input string nm);
    logic oe;
    @(negedge clk);
    bus.op    = op;
    bus.wdata = d;
    oe        = (op == 5'(op_oeacc));
    push(cyc, 1'b1, mk_bus(oe, oe ? cur.acc : 8'h00), {nm, "_bus"});
    push(cyc + 1, 1'b0, nxt, nm);
    cur = nxt;
  endtask

  task automatic reset_mid();
    @(negedge clk);
    #2;
    bus.op    = 5'(op_oeacc);
    bus.wdata = 8'h77;
    rst_n     = 1'b0;
    #1;
    compare("reset_async_state", 1'b0, act_state(), '0);
    compare("reset_async_bus", 1'b1, act_bus(), mk_bus(1'b0, 8'h00));
    bus.op = 5'(op_ldacc);
    @(posedge clk);
    @(negedge clk);
    bus.op = 5'(op_nop);
    rst_n  = 1'b1;
    cur    = '0;
  endtask

  // Monitor
  initial begin
    st_t   e;
    bit    k;
    string nm;
    int    t;
    forever begin
      @(negedge clk);
      #1;
      while (tgt_q.size() > 0 && tgt_q[0] == cyc) begin
        t  = tgt_q.pop_front();
        k  = kind_q.pop_front();
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        compare(nm, k, k ? act_bus() : act_state(), e);
      end
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout at %0t, want test completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Stimulus
  initial begin
    st_t s;
    rst_n     = 1'b0;
    bus.op    = 5'(op_nop);
    bus.wdata = 8'h00;
    cur       = '0;
    repeat (2) @(negedge clk);
    compare("poweron_state", 1'b0, act_state(), '0);
    compare("poweron_bus", 1'b1, act_bus(), mk_bus(1'b0, 8'h00));
    rst_n = 1'b1;

    s = cur; s.acc = 8'h5A;                           issue(op_ldacc, 8'h5A, s, "ldacc_5a");
    reset_mid();
    s = cur;                                          issue(op_nop, 8'h00, s, "inflight_discarded");
    s.z = 1'b1;                                       issue(op_add, 8'h00, s, "add_zero_regs");
    s.e = 1'b1;                                       issue(op_cmpe, 8'h00, s, "cmpe_zero_regs");

    issue(op_lda, 8'hF0, s, "lda_f0");
    issue(op_ldb, 8'h20, s, "ldb_20");
    s.acc = 8'h10; s.c = 1'b1; s.z = 1'b0; s.n = 1'b0; issue(op_add, 8'h00, s, "add_carry");
    issue(op_oeacc, 8'h00, s, "oeacc_10");
    issue(op_nop, 8'h00, s, "nop_after_oe");

    issue(op_lda, 8'h05, s, "lda_05");
    issue(op_ldb, 8'h05, s, "ldb_05");
    s.acc = 8'h00; s.z = 1'b1; s.n = 1'b0; s.c = 1'b0; issue(op_sub, 8'h00, s, "sub_equal");
    issue(op_ldb, 8'h06, s, "ldb_06");
    s.acc = 8'hFF; s.z = 1'b0; s.n = 1'b1; s.c = 1'b1; issue(op_sub, 8'h00, s, "sub_borrow");

    issue(op_lda, 8'h07, s, "lda_07");
    issue(op_ldb, 8'h09, s, "ldb_09");
    s.e = 1'b1;                                       issue(op_cmpl, 8'h00, s, "cmpl_true");
    s.e = 1'b0;                                       issue(op_cmpg, 8'h00, s, "cmpg_false");
    s.e = 1'b0;                                       issue(op_cmpe, 8'h00, s, "cmpe_false");

    issue(op_lda, 8'h37, s, "lda_37");
    s.acc = 8'h07; s.z = 1'b0; s.n = 1'b0; s.e = 1'b1; issue(op_ascii2bin, 8'h00, s, "a2b_digit7");
    issue(op_lda, 8'h66, s, "lda_66");
    s.acc = 8'h0F;                                    issue(op_ascii2bin, 8'h00, s, "a2b_lower_f");
    issue(op_lda, 8'h47, s, "lda_47");
    s.acc = 8'hFF; s.n = 1'b1; s.e = 1'b0;            issue(op_ascii2bin, 8'h00, s, "a2b_invalid");
    issue(op_lda, 8'h30, s, "lda_30");
    s.acc = 8'h00; s.z = 1'b1; s.n = 1'b0; s.e = 1'b1; issue(op_ascii2bin, 8'h00, s, "a2b_digit0");
    issue(op_lda, 8'h3C, s, "lda_3c");
    s.acc = 8'h43; s.z = 1'b0;                        issue(op_bin2ascii, 8'h00, s, "b2a_c");

    issue(op_lda, 8'hCC, s, "lda_cc");
    issue(op_ldb, 8'hAA, s, "ldb_aa");
    s.acc = 8'h88; s.n = 1'b1; s.c = 1'b0;            issue(op_and, 8'h00, s, "and_cc_aa");
    s.acc = 8'hEE;                                    issue(op_or, 8'h00, s, "or_cc_aa");
    s.acc = 8'h66; s.n = 1'b0;                        issue(op_xor, 8'h00, s, "xor_cc_aa");

    s.acc = 8'h81;                                    issue(op_ldacc, 8'h81, s, "ldacc_81");
    s.acc = 8'h02; s.c = 1'b1;                        issue(op_shiftl, 8'h00, s, "shiftl_81");
    s.acc = 8'h01; s.c = 1'b0;                        issue(op_shiftr, 8'h00, s, "shiftr_02");
    s.idx = 8'h01;                                    issue(op_mvacc2id, 8'h00, s, "mvacc2id");
    issue(5'd25, 8'hA5, s, "undefined_25");
    issue(op_mvacc2a, 8'h00, s, "mvacc2a");
    issue(op_mvacc2b, 8'h00, s, "mvacc2b");
    s.acc = 8'h02;                                    issue(op_add, 8'h00, s, "add_moved_regs");
    s.idx = 8'h3F;                                    issue(op_ldid, 8'h3F, s, "ldid_3f");
    issue(op_oeacc, 8'h00, s, "oeacc_02");
    issue(op_nop, 8'h00, s, "nop_final");

    repeat (3) @(negedge clk);
    #2;
    if (tgt_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d unchecked entries, want 0", tgt_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
